csi2_raw10_unpacker: RTL and testbench
======================================

# csi2_raw10_unpacker

Converts the CSI-2 long-packet payload byte stream, 4 bytes per beat, into 40-bit words of four RAW10 pixels each. Sits between the packet header stripper and `csi2_px_serializer`, which consumes the 40-bit words. Implements the 32→40 gearbox and the RAW10 LSB-byte merge, and carries start-of-frame and end-of-line markers through.

## Interface
- `CHECK_LEN`, default 1: 1 enables payload-length alignment checking and `len_err_o`; 0 ties `len_err_o` to 0.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `pkt_i`  `axi4_stream_if.slave`  tdata 32  payload bytes, byte n in tdata[8n+7:8n], byte 0 first on the wire; tuser = SOF on the first beat of a frame's first line; tlast = last payload beat.
- `pkt_o`  `axi4_stream_if.master`  tdata 40  pixels P0..P3 in [9:0], [19:10], [29:20], [39:30]; tuser = SOF; tlast = last group of line.
- `len_err_o`  out  1  one-cycle pulse when the input tlast arrives misaligned.

## Operation
- RAW10 group = 5 bytes B0..B4. B4 = {P3[1:0], P2[1:0], P1[1:0], P0[1:0]}. Pk = {Bk, B4[2k+1:2k]}.
- Byte accumulator holds 8 bytes. Phase FSM PH0..PH4 advances one step per accepted input beat and wraps PH4→PH0.
- Bytes held before each beat: PH0 = 0, PH1 = 4, PH2 = 3, PH3 = 2, PH4 = 1.
- On a beat in PH0, store the 4 bytes and emit nothing.
- On a beat in PH1..PH4, the oldest 5 bytes form one group. Emit it and keep the remainder.
- Steady state: 5 input beats produce 4 output words (20 bytes).
- `pkt_i.tready = !pkt_o.tvalid || pkt_o.tready`. Input is accepted only when the output register is free or draining.
- The output register holds tdata, tuser and tlast stable while `tvalid && !tready`.
- SOF: an accepted beat with tuser = 1 sets `sof_pend`. The next emitted word carries tuser = 1, and emitting it clears `sof_pend`.
  - Simultaneous set and clear (the SOF beat itself emits a word): tuser = 1 on that word, and `sof_pend` ends at 0.
- EOL with tlast in PH4: the emitted group carries tlast = 1. Phase goes to PH0 and the accumulator clears.
- Misaligned tlast (CHECK_LEN = 1):
  - tlast in PH1..PH3: emit the completed group with tlast = 1, drop the leftover bytes, pulse `len_err_o`, go to PH0.
  - tlast in PH0: emit nothing, drop the bytes, pulse `len_err_o`, go to PH0.
  - Valid line widths are multiples of 16 pixels.
- Misaligned tlast (CHECK_LEN = 0): same recovery to PH0, with no pulse.
- tstrb, tkeep = all ones; tid, tdest = 0.

## Timing
- Reset values: `pkt_o.tvalid` = 0, tdata = 0, tuser = 0, tlast = 0; `len_err_o` = 0; phase = PH0; accumulator count = 0; `sof_pend` = 0.
- Latency: output valid the cycle after the input beat that completes a group.
- `len_err_o` is registered and asserts in the same cycle as the corresponding output word, or one cycle after the tlast beat when no word is emitted.
- Backpressure: the downstream serializer accepts one word per 4 cycles. The unpacker must then stall the input and lose nothing.
- Reset mid-line: all state clears in the same cycle. The next beat is treated as PH0.

## Structure
- Shared package `csi2_rx_pkg` holds:
  - `RAW10_GROUP_BYTES` = 5, `RAW10_PX_PER_GROUP` = 4, `RAW10_PX_WIDTH` = 10.
  - Phase enum `raw10_phase_t`, 3-bit.
- Sub-module `csi2_raw10_lsb_merge`: combinational, takes 5 bytes and returns the 40-bit word. It is reused by the RAW10 paths for other lane counts.
- Expected implementation: roughly 150–250 lines.

## Test plan
- Beats 0xDDCCBBAA, then 0x000000E4 as low byte, with no backpressure → first word 0x377_332_2ED_2A8 ({P3,P2,P1,P0}), valid one cycle after beat 2.
- 20-byte line (5 beats, tlast on beat 5, tuser on beat 1) → exactly 4 words; tuser only on word 1, tlast only on word 4; `len_err_o` stays 0.
- Same line with downstream tready high 1 cycle in 4 → identical 4 words; input stalls; no drop or duplicate.
- tlast on beat 3 (PH2) → 2 words, second with tlast = 1; `len_err_o` pulses once; next line decodes correctly from PH0.
- Assert `rst_i` one cycle after beat 2 → outputs go to reset values next cycle; a following clean line matches the golden output.
- Random legal frames (width a multiple of 16 px), randomized tvalid/tready → scoreboard against the reference unpack, zero mismatches over 10k groups.

Source files
------------

// File: rtl/csi2_rx_pkg.sv
// Shared CSI-2 receive definitions: RAW10 geometry and the unpacker phase type.
package csi2_rx_pkg;

  localparam int unsigned RAW10_GROUP_BYTES  = 5;
  localparam int unsigned RAW10_PX_PER_GROUP = 4;
  localparam int unsigned RAW10_PX_WIDTH     = 10;
  localparam int unsigned RAW10_WORD_W       = RAW10_PX_PER_GROUP * RAW10_PX_WIDTH;
  localparam int unsigned RAW10_IN_BYTES     = 4;
  localparam int unsigned RAW10_ACC_BYTES    = 8;

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } raw10_phase_t;

  // Bytes waiting in the accumulator when a beat arrives in a given phase.
  function automatic logic [2:0] phase_held_bytes(input raw10_phase_t ph);
    case (ph)
      PH1:     return 3'd4;
      PH2:     return 3'd3;
      PH3:     return 3'd2;
      PH4:     return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic raw10_phase_t phase_next(input raw10_phase_t ph);
    case (ph)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      PH3:     return PH4;
      default: return PH0;
    endcase
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with a single-bit tuser used as the frame-start marker.
interface axi4_stream_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DEST_W = 4
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;
  logic [ID_W-1:0]       tid;
  logic [DEST_W-1:0]     tdest;
  logic                  tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/csi2_raw10_lsb_merge.sv
// Merges one 5-byte RAW10 group into four 10-bit pixels, P0 in the low bits.
module csi2_raw10_lsb_merge
  import csi2_rx_pkg::*;
(
  input  logic [8*RAW10_GROUP_BYTES-1:0] group_bytes,
  output logic [RAW10_WORD_W-1:0]        word_c
);

  logic [7:0] lsb_byte;

  always_comb begin
    lsb_byte = group_bytes[8*(RAW10_GROUP_BYTES-1) +: 8];
    word_c   = '0;
    for (int k = 0; k < int'(RAW10_PX_PER_GROUP); k++) begin
      word_c[k*RAW10_PX_WIDTH +: RAW10_PX_WIDTH] = {group_bytes[8*k +: 8], lsb_byte[2*k +: 2]};
    end
  end

endmodule

// File: rtl/csi2_raw10_unpacker.sv
// 32->40 bit RAW10 gearbox: packs payload beats into 4-pixel words, carrying SOF/EOL.
module csi2_raw10_unpacker
  import csi2_rx_pkg::*;
#(
  parameter bit CHECK_LEN = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o,
  output logic          len_err_o
);

  localparam int unsigned ACC_W   = 8 * RAW10_ACC_BYTES;
  localparam int unsigned GROUP_W = 8 * RAW10_GROUP_BYTES;

  raw10_phase_t          phase_q, phase_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  sof_pend_q, sof_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [RAW10_WORD_W-1:0] out_data_q, out_data_d;
  logic                  out_user_q, out_user_d;
  logic                  out_last_q, out_last_d;
  logic                  len_err_q, len_err_d;

  logic                  in_ready_c;
  logic                  accept;
  logic                  emit;
  logic [2:0]            held;
  logic [ACC_W-1:0]      merged;
  logic [RAW10_WORD_W-1:0] group_word_c;

  // Oldest bytes sit at the bottom; the new beat lands just above what is held.
  always_comb begin
    held   = phase_held_bytes(phase_q);
    merged = acc_q | (ACC_W'(pkt_i.tdata) << {held, 3'b000});
  end

  csi2_raw10_lsb_merge u_lsb_merge (
    .group_bytes (merged[GROUP_W-1:0]),
    .word_c      (group_word_c)
  );

  assign in_ready_c = !out_valid_q || pkt_o.tready;
  assign accept     = pkt_i.tvalid && in_ready_c;

  always_comb begin
    phase_d     = phase_q;
    acc_d       = acc_q;
    sof_pend_d  = sof_pend_q;
    out_valid_d = out_valid_q && !pkt_o.tready;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
    len_err_d   = 1'b0;
    emit        = 1'b0;

    if (accept) begin
      emit = (phase_q != PH0);
      if (pkt_i.tlast) begin
        // End of line: any partial group is discarded and the gearbox realigns.
        phase_d = PH0;
        acc_d   = '0;
        if (phase_q != PH4) len_err_d = 1'(CHECK_LEN);
      end else begin
        phase_d = phase_next(phase_q);
        acc_d   = emit ? (merged >> GROUP_W) : merged;
      end

      if (emit) begin
        out_valid_d = 1'b1;
        out_data_d  = group_word_c;
        out_user_d  = sof_pend_q || pkt_i.tuser;
        out_last_d  = pkt_i.tlast;
        sof_pend_d  = 1'b0;
      end else if (pkt_i.tuser) begin
        sof_pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q     <= PH0;
      acc_q       <= '0;
      sof_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= 1'b0;
      out_last_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      sof_pend_q  <= sof_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
      len_err_q   <= len_err_d;
    end
  end

  assign pkt_i.tready = in_ready_c;
  assign pkt_o.tvalid = out_valid_q;
  assign pkt_o.tdata  = out_data_q;
  assign pkt_o.tuser  = out_user_q;
  assign pkt_o.tlast  = out_last_q;
  assign pkt_o.tstrb  = '1;
  assign pkt_o.tkeep  = '1;
  assign pkt_o.tid    = '0;
  assign pkt_o.tdest  = '0;
  assign len_err_o    = len_err_q;

  logic unused_sideband;
  assign unused_sideband = ^{pkt_i.tstrb, pkt_i.tkeep, pkt_i.tid, pkt_i.tdest};

endmodule

// File: tb/tb_csi2_raw10_unpacker.sv
// Directed and randomized checks of the RAW10 unpacker against a byte-level model.
module tb_csi2_raw10_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic len_err;

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_W(32)) in_if ();
  axi4_stream_if #(.DATA_W(40)) out_if ();

  csi2_raw10_unpacker #(.CHECK_LEN(1'b1)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pkt_i     (in_if.slave),
    .pkt_o     (out_if.master),
    .len_err_o (len_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] ref_word(input logic [7:0] b0, b1, b2, b3, b4);
    return {b3, b4[7:6], b2, b4[5:4], b1, b4[3:2], b0, b4[1:0]};
  endfunction

  // Downstream ready patterns: 0 always, 1 one-in-four, 2 random, 3 never.
  int rdy_mode = 0;
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       out_if.tready = 1'b1;
      1:       out_if.tready = (cyc % 4 == 0);
      2:       out_if.tready = 1'($urandom % 2);
      default: out_if.tready = 1'b0;
    endcase
  end

  logic [42:0] mon_q[$];
  logic [41:0] exp_q[$];
  int lerr_cnt  = 0;
  int stall_cnt = 0;
  logic last_lerr;

  always @(negedge clk) begin
    if (!rst && out_if.tvalid && out_if.tready)
      mon_q.push_back({len_err, out_if.tlast, out_if.tuser, out_if.tdata});
    if (len_err) lerr_cnt++;
    if (in_if.tvalid && !in_if.tready) stall_cnt++;
  end

  logic [7:0] lb[$];

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    bit done = 1'b0;
    in_if.tvalid = 1'b1;
    in_if.tdata  = d;
    in_if.tuser  = u;
    in_if.tlast  = l;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_if.tready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_if.tvalid = 1'b0;
    if (!done) check_eq("beat_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_line(input int nbeats, input bit sof, input int gap_max);
    for (int b = 0; b < nbeats; b++) begin
      if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
      send_beat({lb[4*b+3], lb[4*b+2], lb[4*b+1], lb[4*b]}, sof && (b == 0), b == nbeats - 1);
    end
  endtask

  // Beats landing in PH0 never emit; a tlast landing there leaves no tagged word.
  task automatic expect_line(input int nbeats, input bit sof);
    int ng = nbeats - (nbeats + 4) / 5;
    bit tl = (nbeats % 5) != 1;
    for (int g = 0; g < ng; g++)
      exp_q.push_back({tl && (g == ng - 1), sof && (g == 0),
                       ref_word(lb[5*g], lb[5*g+1], lb[5*g+2], lb[5*g+3], lb[5*g+4])});
  endtask

  task automatic check_words(input string tag);
    logic [42:0] m;
    logic [41:0] e;
    int i = 0;
    for (int n = 0; n < 1000 && mon_q.size() < exp_q.size(); n++) idle(1);
    idle(8);
    check_eq({tag, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mon_q.pop_front();
      last_lerr = m[42];
      check_eq($sformatf("%s_w%0d_data", tag, i), 64'(m[39:0]), 64'(e[39:0]));
      check_eq($sformatf("%s_w%0d_user", tag, i), 64'(m[40]), 64'(e[40]));
      check_eq($sformatf("%s_w%0d_last", tag, i), 64'(m[41]), 64'(e[41]));
      i++;
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic fill_line(input int nbytes, input bit rnd);
    lb.delete();
    for (int i = 0; i < nbytes; i++)
      lb.push_back(rnd ? 8'($urandom) : 8'(8'h13 + 8'(i) * 8'h2B));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  initial begin
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tuser  = 1'b0;
    in_if.tlast  = 1'b0;
    in_if.tstrb  = '1;
    in_if.tkeep  = '1;
    in_if.tid    = '0;
    in_if.tdest  = '0;
    out_if.tready = 1'b1;
    idle(3);
    rst = 1'b0;

    @(negedge clk);
    check_eq("rst_tvalid", 64'(out_if.tvalid), 64'(0));
    check_eq("rst_tdata",  64'(out_if.tdata),  64'(0));
    check_eq("rst_tuser",  64'(out_if.tuser),  64'(0));
    check_eq("rst_tlast",  64'(out_if.tlast),  64'(0));
    check_eq("rst_len_err", 64'(len_err),      64'(0));
    check_eq("rst_in_ready", 64'(in_if.tready), 64'(1));
    idle(1);

    // First group and its one-cycle latency.
    send_beat(32'hDDCC_BBAA, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("t1_no_word_after_beat1", 64'(out_if.tvalid), 64'(0));
    idle(1);
    send_beat(32'h0000_00E4, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("t1_valid", 64'(out_if.tvalid), 64'(1));
    check_eq("t1_data", 64'(out_if.tdata), 64'({10'h377, 10'h332, 10'h2ED, 10'h2A8}));
    idle(2);
    do_reset();
    mon_q.delete();

    // Aligned 20-byte line, free-running downstream.
    lerr_cnt = 0;
    fill_line(20, 1'b0);
    send_line(5, 1'b1, 0);
    expect_line(5, 1'b1);
    check_words("line");
    check_eq("line_lerr", 64'(lerr_cnt), 64'(0));

    // Same line with downstream ready one cycle in four.
    rdy_mode = 1;
    stall_cnt = 0;
    send_line(5, 1'b1, 0);
    expect_line(5, 1'b1);
    check_words("bp");
    check_eq("bp_stalled", 64'(stall_cnt > 0), 64'(1));
    rdy_mode = 0;
    idle(2);

    // tlast in PH2: two words, the second tagged, one error pulse.
    lerr_cnt = 0;
    send_line(3, 1'b1, 0);
    expect_line(3, 1'b1);
    check_words("short");
    check_eq("short_lerr_cnt", 64'(lerr_cnt), 64'(1));
    check_eq("short_lerr_with_word", 64'(last_lerr), 64'(1));
    send_line(5, 1'b0, 0);
    expect_line(5, 1'b0);
    check_words("after_short");

    // tlast in PH0: nothing emitted for that beat, one error pulse.
    lerr_cnt = 0;
    fill_line(24, 1'b0);
    send_line(6, 1'b0, 0);
    expect_line(6, 1'b0);
    check_words("ph0_last");
    check_eq("ph0_last_lerr_cnt", 64'(lerr_cnt), 64'(1));
    send_line(5, 1'b0, 0);
    expect_line(5, 1'b0);
    check_words("after_ph0");

    // Reset mid-line with a word held in the output register.
    rdy_mode = 3;
    idle(2);
    send_line(2, 1'b1, 0);
    idle(1);
    check_eq("mid_held_valid", 64'(out_if.tvalid), 64'(1));
    do_reset();
    @(negedge clk);
    check_eq("mid_rst_tvalid", 64'(out_if.tvalid), 64'(0));
    check_eq("mid_rst_tdata",  64'(out_if.tdata),  64'(0));
    check_eq("mid_rst_tuser",  64'(out_if.tuser),  64'(0));
    check_eq("mid_rst_tlast",  64'(out_if.tlast),  64'(0));
    mon_q.delete();
    rdy_mode = 0;
    idle(2);
    fill_line(20, 1'b0);
    send_line(5, 1'b1, 0);
    expect_line(5, 1'b1);
    check_words("post_rst");

    // Random legal frames with random gaps and backpressure.
    rdy_mode = 2;
    lerr_cnt = 0;
    for (int f = 0; f < 6; f++) begin
      for (int l = 0; l < 3; l++) begin
        int nb = 5 * int'($urandom_range(1, 4));
        fill_line(4 * nb, 1'b1);
        send_line(nb, l == 0, 2);
        expect_line(nb, l == 0);
        check_words($sformatf("rnd_f%0d_l%0d", f, l));
      end
    end
    check_eq("rnd_lerr", 64'(lerr_cnt), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
